// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with lock-stability filter and timeout handling
// Optional feature macro: PLL_LOCK_RETRY_EN (timeouts retry the PLL reset instead of parking in FAULT)
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  localparam logic [20:0] RST_LAST     = 21'(RST_PULSE_CYCLES - 1);
  localparam logic [20:0] STABLE_LAST  = 21'(LOCK_STABLE_CYCLES - 1);
  localparam logic [20:0] TIMEOUT_LAST = 21'(LOCK_TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        sync1_q, locked_s_q;
  logic        pll_rst_q, core_rst_n_q, ready_q, fault_q;
  logic        fault_d;

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Next-state, shared counter and retry bookkeeping; restart_req overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 21'd1;
    retry_d = retry_q;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
`ifdef PLL_LOCK_RETRY_EN
          state_d = ST_RESET_PLL;
`else
          state_d = ST_FAULT;
`endif
        end
      end
      ST_STABLE: begin
        if (!locked_s_q)               state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s_q) state_d = ST_RESET_PLL;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    if (restart_req) begin
      state_d = ST_RESET_PLL;
      retry_d = retry_q;
    end
    // Restart inside RESET_PLL keeps the state but must still restart the pulse count
    if (restart_req || (state_d != state_q)) cnt_d = '0;
  end

  // Fault flag source differs between the retrying and the parking variant
  always_comb begin
`ifdef PLL_LOCK_RETRY_EN
    fault_d = (retry_d == 4'hF);
`else
    fault_d = (state_d == ST_FAULT);
`endif
  end

  // State, counter, retry count and outputs all registered from next-state values
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == ST_RESET_PLL);
      core_rst_n_q <= (state_d == ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fault_q      <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_rst_n  = core_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int b_edge;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart_req(restart_req),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance to 1 time unit after the given post-release edge number
  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(posedge refclk);
      #1;
      edge_n++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    #23;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_count, 0);

    @(posedge refclk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;

    // Nominal: pll_rst across edges 1-4, lock sampled at edge 10, ready after edge 20
    step_to(3);  check("nom_pll_rst_e3", pll_rst, 1);
    step_to(4);  check("nom_pll_rst_e4", pll_rst, 0);
    check("nom_core_rst_e4", core_rst_n, 0);
    step_to(9);  pll_locked = 1'b1;
    step_to(19); check("nom_ready_e19", ready, 0);
    step_to(20); check("nom_ready_e20", ready, 1);
    check("nom_core_rst_e20", core_rst_n, 1);

    // Loss in RUN: drop after edge 22, reset appears after the third edge
    step_to(22); pll_locked = 1'b0;
    step_to(24); check("loss_core_e24", core_rst_n, 1);
    step_to(25); check("loss_core_e25", core_rst_n, 0);
    check("loss_pll_rst_e25", pll_rst, 1);
    check("loss_ready_e25", ready, 0);
    check("loss_retry", retry_count, 0);

    // Glitch in STABLE: one-cycle drop forces a full recount
    step_to(30); pll_locked = 1'b1;
    step_to(35); pll_locked = 1'b0;
    step_to(36); pll_locked = 1'b1;
    step_to(41); check("glitch_ready_e41", ready, 0);
    step_to(46); check("glitch_ready_e46", ready, 0);
    step_to(47); check("glitch_ready_e47", ready, 1);
    check("glitch_retry", retry_count, 0);

    // restart_req coincident with locked_s fall in RUN
    step_to(50); pll_locked = 1'b0;
    step_to(52); check("rst_req_ready_e52", ready, 1);
    restart_req = 1'b1;
    step_to(53); restart_req = 1'b0;
    check("rst_req_pll_rst_e53", pll_rst, 1);
    check("rst_req_core_e53", core_rst_n, 0);
    step_to(56); check("rst_req_pll_rst_e56", pll_rst, 1);
    step_to(57); check("rst_req_pll_rst_e57", pll_rst, 0);

    // Timeout with lock held low: first timeout at edge 89
    step_to(88); check("to_retry_e88", retry_count, 0);
    check("to_fault_e88", fault, 0);
    step_to(89); check("to_retry_e89", retry_count, 1);
`ifdef PLL_LOCK_RETRY_EN
    check("to_pll_rst_e89", pll_rst, 1);
    check("to_fault_e89", fault, 0);
    step_to(125); check("to_retry_e125", retry_count, 2);
    step_to(592); check("to_retry_e592", retry_count, 14);
    check("to_fault_e592", fault, 0);
    step_to(593); check("to_retry_e593", retry_count, 15);
    check("to_fault_e593", fault, 1);
    step_to(629); check("to_retry_sat_e629", retry_count, 15);
    check("to_pll_rst_e629", pll_rst, 1);
    step_to(633); check("to_pll_rst_e633", pll_rst, 0);
    check("to_fault_e633", fault, 1);
    b_edge = 633;
`else
    check("to_fault_e89", fault, 1);
    check("to_pll_rst_e89", pll_rst, 0);
    check("to_core_e89", core_rst_n, 0);
    step_to(92); pll_locked = 1'b1;
    step_to(100); check("fault_hold_e100", fault, 1);
    check("fault_ready_e100", ready, 0);
    restart_req = 1'b1;
    step_to(101); restart_req = 1'b0;
    check("fault_exit_fault", fault, 0);
    check("fault_exit_pll_rst", pll_rst, 1);
    check("fault_exit_retry", retry_count, 1);
    b_edge = 101;
`endif

    // Asynchronous reset while in STABLE
    pll_locked = 1'b1;
    restart_req = 1'b1;
    step_to(b_edge + 1); restart_req = 1'b0;
    step_to(b_edge + 8);
    check("stable_pll_rst", pll_rst, 0);
    check("stable_ready", ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_core", core_rst_n, 0);
    check("async_ready", ready, 0);
    check("async_fault", fault, 0);
    check("async_retry", retry_count, 0);

    // Release again and confirm a clean relock
    @(posedge refclk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    step_to(4);  check("rerel_pll_rst_e4", pll_rst, 0);
    step_to(14); check("rerel_ready_e14", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The module SHALL have the parameter RST_PULSE_CYCLES, default 16: number of refclk cycles that pll_rst is held high per PLL reset.
REQ-002 The module SHALL have the parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive locked cycles required before release.
REQ-003 The module SHALL have the parameter LOCK_TIMEOUT_CYCLES, default 1048576: maximum refclk cycles spent waiting for lock per attempt.
REQ-004 The module SHALL have the port refclk, input, 1 bit: single clock (74.25 MHz PLL reference); all logic is on its rising edge.
REQ-005 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have the port pll_locked, input, 1 bit: PLL locked indication, asynchronous to refclk.
REQ-007 The module SHALL have the port restart_req, input, 1 bit: single-cycle request to re-run the full lock sequence.
REQ-008 The module SHALL have the port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-009 The module SHALL have the port core_rst_n, output, 1 bit: active-low reset for logic clocked by the PLL output clocks.
REQ-010 The module SHALL have the port ready, output, 1 bit: high while the PLL is locked and the core is released.
REQ-011 The module SHALL have the port fault, output, 1 bit: lock-failure indication.
REQ-012 The module SHALL have the port retry_count, output, 4 bits: number of lock timeouts.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer (reset 0) to give locked_s; only locked_s is used internally.
REQ-014 The state machine SHALL have the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, and one shared 21-bit cycle counter.
REQ-015 The counter SHALL clear to 0 on every state transition.
REQ-016 All outputs SHALL be decoded from state and retry registers only, with no combinational path from any input.
REQ-017 In RESET_PLL: pll_rst=1, core_rst_n=0, ready=0; after RST_PULSE_CYCLES cycles the state SHALL go to WAIT_LOCK.
REQ-018 In WAIT_LOCK: pll_rst=0, core_rst_n=0; locked_s=1 SHALL go to STABLE on the next edge; reaching count LOCK_TIMEOUT_CYCLES-1 with locked_s=0 SHALL be a timeout (see Configuration).
REQ-019 In STABLE: locked_s=0 SHALL go to WAIT_LOCK with the counter cleared; completing LOCK_STABLE_CYCLES consecutive locked cycles SHALL go to RUN.
REQ-020 In RUN: core_rst_n=1 and ready=1; locked_s=0 SHALL go to RESET_PLL, so core_rst_n falls one edge after locked_s falls.
REQ-021 restart_req=1 in any state SHALL go to RESET_PLL with the counter cleared; this takes priority over all other transitions in the same cycle.
REQ-022 A loss of lock and a timeout occurring together SHALL resolve to the loss-of-lock transition.
REQ-023 retry_count SHALL increment on each timeout and saturate at 15; no wrap; it is cleared only by rst_n.
REQ-024 Latency: after a pll_locked rise is sampled at edge e0, ready SHALL be 1 after edge e0+2+LOCK_STABLE_CYCLES, provided lock holds.

Reset
REQ-025 rst_n low SHALL asynchronously force state=RESET_PLL, counter=0, pll_rst=1, core_rst_n=0, ready=0, fault=0, retry_count=0 and the synchronizer to 0.
REQ-026 Release of rst_n SHALL take effect on the next refclk edge, starting the RESET_PLL pulse count from 0.
REQ-027 Assertion of rst_n mid-sequence SHALL abandon the sequence without waiting for the current state to complete.

Configuration
REQ-028 With macro PLL_LOCK_RETRY_EN defined, a timeout SHALL go to RESET_PLL and increment retry_count.
REQ-029 With PLL_LOCK_RETRY_EN defined, fault SHALL be 1 whenever retry_count=15, and retries SHALL continue; fault clears only by rst_n.
REQ-030 Without PLL_LOCK_RETRY_EN, a timeout SHALL go to FAULT and increment retry_count.
REQ-031 In FAULT (macro undefined): pll_rst=0, core_rst_n=0, ready=0, fault=1; exit SHALL be only via restart_req (to RESET_PLL, fault=0) or rst_n.
REQ-032 With PLL_LOCK_RETRY_EN defined, the FAULT state SHALL be unreachable.

Verification (parameters RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-033 Nominal: release rst_n and raise pll_locked at edge 10 -> pll_rst high for edges 1-4; ready=1 and core_rst_n=1 after edge 20.
REQ-034 Glitch in STABLE: pll_locked low for 1 cycle during STABLE -> return to WAIT_LOCK; ready delayed by a full 8-cycle recount; retry_count=0.
REQ-035 Loss in RUN: drop pll_locked while ready=1 -> core_rst_n=0 and pll_rst=1 three edges after the drop; sequence restarts.
REQ-036 Timeout with macro: pll_locked held 0 -> retry_count increments every 36 cycles, saturates at 15 with fault=1, and pll_rst keeps pulsing.
REQ-037 Timeout without macro: pll_locked held 0 -> FAULT after 36 cycles, fault=1, retry_count=1; restart_req -> RESET_PLL and fault=0.
REQ-038 Reset and restart during the sequence: rst_n low during STABLE -> all outputs at reset values immediately and asynchronously; restart_req in the same cycle as a locked_s fall in RUN -> RESET_PLL.
